// File: rtl/r2_pipeline_arbiter.sv
// Round-robin arbiter that shares one fixed-latency r2 pipeline among NUM_REQ requesters.
// An ID tag shift register tracks each issue so results return to their owner in issue order.
module r2_pipeline_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned ID_WIDTH     = 2,
   parameter int unsigned PIPE_LATENCY = 17
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_last,
   input  logic [NUM_REQ*6*DATA_WIDTH-1:0] req_coord,
   output logic [NUM_REQ-1:0]              req_grant,
   output logic                            pipe_enable,
   output logic [DATA_WIDTH-1:0]           pipe_refx,
   output logic [DATA_WIDTH-1:0]           pipe_refy,
   output logic [DATA_WIDTH-1:0]           pipe_refz,
   output logic [DATA_WIDTH-1:0]           pipe_neighborx,
   output logic [DATA_WIDTH-1:0]           pipe_neighbory,
   output logic [DATA_WIDTH-1:0]           pipe_neighborz,
   input  logic [DATA_WIDTH-1:0]           pipe_r2,
   input  logic [DATA_WIDTH-1:0]           pipe_dx,
   input  logic [DATA_WIDTH-1:0]           pipe_dy,
   input  logic [DATA_WIDTH-1:0]           pipe_dz,
   input  logic                            pipe_r2_valid,
   output logic                            rsp_valid,
   output logic [ID_WIDTH-1:0]             rsp_id,
   output logic [DATA_WIDTH-1:0]           rsp_r2,
   output logic [DATA_WIDTH-1:0]           rsp_dx,
   output logic [DATA_WIDTH-1:0]           rsp_dy,
   output logic [DATA_WIDTH-1:0]           rsp_dz,
   output logic                            busy,
   output logic                            done,
   output logic [15:0]                     pair_count,
   output logic                            tag_error
);

   localparam int unsigned CoordW = 6 * DATA_WIDTH;
   localparam int unsigned BlankW = $clog2(PIPE_LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                  state_q;
   logic [ID_WIDTH-1:0]     rr_ptr_q;
   logic [ID_WIDTH-1:0]     grant_idx;
   logic [ID_WIDTH-1:0]     next_ptr;
   logic [ID_WIDTH-1:0]     pipe_id_q;
   logic [NUM_REQ-1:0]      finished_q;
   logic [NUM_REQ-1:0]      eligible;
   logic                    grant_any;
   logic [CoordW-1:0]       sel_coord;
   logic [PIPE_LATENCY-1:0] tag_v_q;
   logic [ID_WIDTH-1:0]     tag_id_q [PIPE_LATENCY];
   logic [BlankW-1:0]       blank_q;
   logic                    blank;
   logic                    tag_out_v;

   assign busy      = (state_q != StIdle);
   assign tag_out_v = tag_v_q[PIPE_LATENCY-1];
   // Results still emerging from a pipeline issued before reset are ignored for one latency.
   assign blank     = (blank_q != '0);

   always_comb begin : arb
      int unsigned cand;
      cand      = 0;
      eligible  = req_valid & ~finished_q;
      grant_any = 1'b0;
      grant_idx = '0;
      req_grant = '0;
      if (state_q == StRun) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_any && eligible[cand[ID_WIDTH-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = cand[ID_WIDTH-1:0];
            end
         end
      end
      if (grant_any) begin
         req_grant[grant_idx] = 1'b1;
      end
      next_ptr  = ID_WIDTH'((32'(grant_idx) + 1) % NUM_REQ);
      sel_coord = req_coord[32'(grant_idx) * CoordW +: CoordW];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q       <= '0;
         pipe_enable    <= 1'b0;
         pipe_id_q      <= '0;
         pipe_refx      <= '0;
         pipe_refy      <= '0;
         pipe_refz      <= '0;
         pipe_neighborx <= '0;
         pipe_neighbory <= '0;
         pipe_neighborz <= '0;
         tag_v_q        <= '0;
         for (int i = 0; i < PIPE_LATENCY; i++) begin
            tag_id_q[i] <= '0;
         end
         blank_q        <= BlankW'(PIPE_LATENCY);
         rsp_valid      <= 1'b0;
         rsp_id         <= '0;
         rsp_r2         <= '0;
         rsp_dx         <= '0;
         rsp_dy         <= '0;
         rsp_dz         <= '0;
      end else begin
         pipe_enable <= grant_any;
         if (grant_any) begin
            rr_ptr_q       <= next_ptr;
            pipe_id_q      <= grant_idx;
            pipe_refx      <= sel_coord[6*DATA_WIDTH-1 -: DATA_WIDTH];
            pipe_refy      <= sel_coord[5*DATA_WIDTH-1 -: DATA_WIDTH];
            pipe_refz      <= sel_coord[4*DATA_WIDTH-1 -: DATA_WIDTH];
            pipe_neighborx <= sel_coord[3*DATA_WIDTH-1 -: DATA_WIDTH];
            pipe_neighbory <= sel_coord[2*DATA_WIDTH-1 -: DATA_WIDTH];
            pipe_neighborz <= sel_coord[DATA_WIDTH-1:0];
         end
         tag_v_q     <= {tag_v_q[PIPE_LATENCY-2:0], pipe_enable};
         tag_id_q[0] <= pipe_id_q;
         for (int i = 1; i < PIPE_LATENCY; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
         end
         if (blank) begin
            blank_q <= blank_q - BlankW'(1);
         end
         rsp_valid <= pipe_r2_valid & ~blank;
         if (pipe_r2_valid && !blank) begin
            rsp_id <= tag_id_q[PIPE_LATENCY-1];
            rsp_r2 <= pipe_r2;
            rsp_dx <= pipe_dx;
            rsp_dy <= pipe_dy;
            rsp_dz <= pipe_dz;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         finished_q <= '0;
         pair_count <= '0;
         done       <= 1'b0;
         tag_error  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!blank && (tag_out_v != pipe_r2_valid)) begin
            tag_error <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StRun;
                  pair_count <= '0;
                  finished_q <= '0;
                  tag_error  <= 1'b0;
               end
            end
            StRun: begin
               if (grant_any) begin
                  if (pair_count != 16'hFFFF) begin
                     pair_count <= pair_count + 16'd1;
                  end
                  if (req_last[grant_idx]) begin
                     finished_q[grant_idx] <= 1'b1;
                  end
               end
               if (&finished_q) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (!(|tag_v_q) && !pipe_enable) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_r2_pipeline_arbiter.sv
// Directed bench for r2_pipeline_arbiter: arbitration vector table plus frame, drain,
// mid-frame reset and tag-error sequences against a 17-cycle pipeline model.
module tb_r2_pipeline_arbiter;

   localparam int DW  = 32;
   localparam int NR  = 4;
   localparam int IW  = 2;
   localparam int LAT = 17;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR-1:0]      req_last = '0;
   logic [NR*6*DW-1:0] req_coord = '0;
   logic [NR-1:0]      req_grant;
   logic               pipe_enable;
   logic [DW-1:0]      pipe_refx, pipe_refy, pipe_refz;
   logic [DW-1:0]      pipe_neighborx, pipe_neighbory, pipe_neighborz;
   logic [DW-1:0]      pipe_r2, pipe_dx, pipe_dy, pipe_dz;
   logic               pipe_r2_valid;
   logic               rsp_valid;
   logic [IW-1:0]      rsp_id;
   logic [DW-1:0]      rsp_r2, rsp_dx, rsp_dy, rsp_dz;
   logic               busy, done, tag_error;
   logic [15:0]        pair_count;

   r2_pipeline_arbiter #(
      .DATA_WIDTH  (DW),
      .NUM_REQ     (NR),
      .ID_WIDTH    (IW),
      .PIPE_LATENCY(LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_coord     (req_coord),
      .req_grant     (req_grant),
      .pipe_enable   (pipe_enable),
      .pipe_refx     (pipe_refx),
      .pipe_refy     (pipe_refy),
      .pipe_refz     (pipe_refz),
      .pipe_neighborx(pipe_neighborx),
      .pipe_neighbory(pipe_neighbory),
      .pipe_neighborz(pipe_neighborz),
      .pipe_r2       (pipe_r2),
      .pipe_dx       (pipe_dx),
      .pipe_dy       (pipe_dy),
      .pipe_dz       (pipe_dz),
      .pipe_r2_valid (pipe_r2_valid),
      .rsp_valid     (rsp_valid),
      .rsp_id        (rsp_id),
      .rsp_r2        (rsp_r2),
      .rsp_dx        (rsp_dx),
      .rsp_dy        (rsp_dy),
      .rsp_dz        (rsp_dz),
      .busy          (busy),
      .done          (done),
      .pair_count    (pair_count),
      .tag_error     (tag_error)
   );

   always #5 clk = ~clk;

   // Pipeline model: never reset, r2 = refx + nbx, dx = refx - nbx, LAT cycles after issue.
   logic [LAT-1:0] mv = '0;
   logic [DW-1:0]  mr2 [LAT];
   logic [DW-1:0]  mdx [LAT];
   logic           inject = 1'b0;

   always @(posedge clk) begin
      mv     <= {mv[LAT-2:0], pipe_enable};
      mr2[0] <= pipe_refx + pipe_neighborx;
      mdx[0] <= pipe_refx - pipe_neighborx;
      for (int i = 1; i < LAT; i++) begin
         mr2[i] <= mr2[i-1];
         mdx[i] <= mdx[i-1];
      end
   end

   assign pipe_r2_valid = mv[LAT-1] | inject;
   assign pipe_r2       = mr2[LAT-1];
   assign pipe_dx       = mdx[LAT-1];
   assign pipe_dy       = '0;
   assign pipe_dz       = '0;

   typedef struct {
      int          id;
      int          gcyc;
      logic [31:0] r2;
      logic [31:0] dx;
   } exp_t;

   typedef struct {
      logic [3:0] v;
      logic [3:0] l;
      logic [3:0] g;
   } vec_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          cnt [NR];
   exp_t        sbq [$];
   int          gorder [$];
   int          gcycs [$];
   bit          sb_en = 1'b1;
   bit          exp_pe = 1'b0;
   logic [31:0] exp_refx, exp_nbz;
   int          last_rsp_cyc = 0;
   int          npulses = 0;
   vec_t        tbl [12];

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] coord(int r, int k, int f);
      return 32'(r * 4096 + k * 256 + f * 16 + 1);
   endfunction

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (pipe_r2_valid) npulses++;
      check("pipe_enable", {63'd0, pipe_enable}, {63'd0, exp_pe});
      if (exp_pe) begin
         check("pipe_refx", pipe_refx, exp_refx);
         check("pipe_neighborz", pipe_neighborz, exp_nbz);
      end
      if (rsp_valid && sb_en) begin
         if (sbq.size() == 0) begin
            check("rsp_unexpected", 1, 0);
         end else begin
            e = sbq.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_r2", rsp_r2, e.r2);
            check("rsp_dx", rsp_dx, e.dx);
            check("rsp_latency", cyc - e.gcyc, 19);
            last_rsp_cyc = cyc;
         end
      end
   endtask

   task automatic apply(input logic [NR-1:0] v, input logic [NR-1:0] l);
      exp_t e;
      req_valid = v;
      req_last  = l;
      for (int r = 0; r < NR; r++) begin
         for (int f = 0; f < 6; f++) begin
            req_coord[r*192 + (5-f)*32 +: 32] = coord(r, cnt[r], f);
         end
      end
      #1;
      exp_pe = 1'b0;
      for (int r = 0; r < NR; r++) begin
         if (req_grant[r] === 1'b1 && v[r]) begin
            exp_pe   = 1'b1;
            exp_refx = coord(r, cnt[r], 0);
            exp_nbz  = coord(r, cnt[r], 5);
            e.id     = r;
            e.gcyc   = cyc;
            e.r2     = coord(r, cnt[r], 0) + coord(r, cnt[r], 3);
            e.dx     = coord(r, cnt[r], 0) - coord(r, cnt[r], 3);
            sbq.push_back(e);
            gorder.push_back(r);
            gcycs.push_back(cyc);
            cnt[r]++;
         end
      end
   endtask

   task automatic do_reset();
      sbq.delete();
      rst = 1'b1;
      apply('0, '0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         apply('0, '0);
         tick();
      end
   endtask

   task automatic begin_frame();
      for (int r = 0; r < NR; r++) cnt[r] = 0;
      gorder.delete();
      gcycs.delete();
      start = 1'b1;
      apply('0, '0);
      tick();
      start = 1'b0;
   endtask

   // Each requester offers npairs pairs, marking the final one last.
   task automatic run_frame(input int npairs);
      logic [NR-1:0] v, l;
      bit            fin = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
         for (int r = 0; r < NR; r++) begin
            v[r] = (cnt[r] < npairs);
            l[r] = (cnt[r] == npairs - 1);
         end
         apply(v, l);
         tick();
         fin = 1'b1;
         for (int r = 0; r < NR; r++) if (cnt[r] < npairs) fin = 1'b0;
      end
      check("frame_complete", {63'd0, fin}, 1);
   endtask

   task automatic wait_done(input int exp_pairs);
      int dcyc  = -1;
      int ndone = 0;
      bit ended = 1'b0;
      for (int i = 0; i < 80 && !ended; i++) begin
         apply('0, '0);
         tick();
         if (done) begin
            ndone++;
            dcyc = cyc;
         end else if (dcyc >= 0) begin
            check("busy_after_done", {63'd0, busy}, 0);
            ended = 1'b1;
         end else begin
            check("busy_drain", {63'd0, busy}, 1);
         end
      end
      check("done_seen", {63'd0, ended}, 1);
      check("done_pulses", ndone, 1);
      check("done_after_last_rsp", dcyc, last_rsp_cyc + 1);
      check("pair_count", pair_count, exp_pairs);
      check("sb_empty", sbq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Arbitration table for one frame starting from pointer 0.
      tbl[0]  = '{4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b0100, 4'b0000, 4'b0100};
      tbl[2]  = '{4'b1111, 4'b0000, 4'b1000};
      tbl[3]  = '{4'b1111, 4'b0000, 4'b0001};
      tbl[4]  = '{4'b0101, 4'b0000, 4'b0100};
      tbl[5]  = '{4'b0011, 4'b0010, 4'b0001};
      tbl[6]  = '{4'b0011, 4'b0010, 4'b0010};
      tbl[7]  = '{4'b0010, 4'b0000, 4'b0000};
      tbl[8]  = '{4'b1111, 4'b1101, 4'b0100};
      tbl[9]  = '{4'b1111, 4'b1101, 4'b1000};
      tbl[10] = '{4'b1111, 4'b1111, 4'b0001};
      tbl[11] = '{4'b1111, 4'b0000, 4'b0000};

      for (int r = 0; r < NR; r++) cnt[r] = 0;

      // Reset state and no grant in IDLE.
      do_reset();
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_done", {63'd0, done}, 0);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_r2", rsp_r2, 0);
      check("rst_pair_count", pair_count, 0);
      check("rst_tag_error", {63'd0, tag_error}, 0);
      check("rst_pipe_refx", pipe_refx, 0);
      apply(4'b1111, 4'b0000);
      check("grant_idle", req_grant, 0);
      tick();

      // Table-driven arbitration, finished masking and drain.
      begin_frame();
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].v, tbl[i].l);
         check($sformatf("grant_row%0d", i), req_grant, tbl[i].g);
         tick();
      end
      wait_done(9);

      // Single pair per requester.
      do_reset();
      begin_frame();
      run_frame(1);
      check("single_n", gorder.size(), 4);
      for (int i = 0; i < 4 && i < gorder.size(); i++) begin
         check($sformatf("single_order%0d", i), gorder[i], i);
      end
      wait_done(4);

      // Fairness, back-to-back issue, start ignored while running.
      do_reset();
      begin_frame();
      start = 1'b1;
      run_frame(2);
      start = 1'b0;
      check("fair_n", gorder.size(), 8);
      for (int i = 0; i < 8 && i < gorder.size(); i++) begin
         check($sformatf("fair_order%0d", i), gorder[i], i % 4);
      end
      if (gcycs.size() == 8) check("fair_back_to_back", gcycs[7] - gcycs[0], 7);
      wait_done(8);

      // Reset with five pairs in flight; late pipeline results must be ignored.
      do_reset();
      begin_frame();
      repeat (5) begin
         apply(4'b1111, 4'b0000);
         tick();
      end
      npulses = 0;
      do_reset();
      idle(25);
      check("midrst_pulses_seen", npulses, 5);
      check("midrst_tag_error", {63'd0, tag_error}, 0);
      check("midrst_busy", {63'd0, busy}, 0);
      check("midrst_pair_count", pair_count, 0);

      // Spurious result with no tag sets a sticky error cleared only by start.
      sb_en  = 1'b0;
      inject = 1'b1;
      apply('0, '0);
      tick();
      inject = 1'b0;
      check("tag_error_set", {63'd0, tag_error}, 1);
      idle(5);
      check("tag_error_sticky", {63'd0, tag_error}, 1);
      sb_en = 1'b1;
      begin_frame();
      check("tag_error_cleared", {63'd0, tag_error}, 0);
      run_frame(1);
      wait_done(4);
      check("tag_error_clean_frame", {63'd0, tag_error}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
